// File: rtl/stack_seq_pkg.sv
// Shared constants for the stack-machine command sequencer: opcodes,
// FSM state encoding, error bit positions and small opcode decoders.
package stack_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_PUSHI = 3'b000;
  localparam logic [OP_W-1:0] OP_DROP  = 3'b001;
  localparam logic [OP_W-1:0] OP_PEEK  = 3'b010;
  localparam logic [OP_W-1:0] OP_DUP   = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b101;
  localparam logic [OP_W-1:0] OP_AND   = 3'b110;
  localparam logic [OP_W-1:0] OP_NOT   = 3'b111;

  localparam int ERR_UNDER = 0;
  localparam int ERR_OVER  = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP_A   = 3'd1,
    ST_TOS_A   = 3'd2,
    ST_CAP_A   = 3'd3,
    ST_CAP_B   = 3'd4,
    ST_PUSH_R  = 3'd5,
    ST_RESTORE = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Two-operand ops that pop a second entry after the first capture.
  function automatic logic is_binop(input logic [OP_W-1:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND);
  endfunction

  // Ops whose result is the captured value itself; they finish in CAP_A.
  function automatic logic is_readout(input logic [OP_W-1:0] o);
    return (o == OP_DROP) || (o == OP_PEEK);
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational result path for the value pushed in PUSH_R.
// a is the first captured operand (old top of stack), b the second.
// Optional flags (carry/borrow and zero) exist when STACK_SEQ_FLAGS_EN is defined.
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
`ifdef STACK_SEQ_FLAGS_EN
  ,
  output logic             c,
  output logic             z
`endif
);

  // Result select; pass-through of a covers PUSHI (imm loaded into a) and DUP.
  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
      OP_AND:  result = b & a;
      OP_NOT:  result = ~a;
      default: result = a;
    endcase
  end

`ifdef STACK_SEQ_FLAGS_EN
  logic [WIDTH:0] sum;

  // Carry-out for ADD, borrow for SUB, zero otherwise; z tracks the result.
  always_comb begin
    sum = {1'b0, b} + {1'b0, a};
    c   = 1'b0;
    if (op == OP_ADD)      c = sum[WIDTH];
    else if (op == OP_SUB) c = (b < a);
    z = (result == '0);
  end
`endif

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack-machine command sequencer: sole master of the Stack block.
// Accepts one command at a time, drives push/pop/tos strobes, captures the
// Stack's registered data_out into operands a/b and pushes ALU results back.
// Optional: define STACK_SEQ_FLAGS_EN to add flag_c/flag_z outputs.
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             stk_tos,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             done,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       err
`ifdef STACK_SEQ_FLAGS_EN
  ,
  output logic             flag_c,
  output logic             flag_z
`endif
);

  state_t           state;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a, b, res_q;
  logic             ready_q, done_q, push_q, pop_q, tos_q;
  logic [1:0]       err_q;
  logic [WIDTH-1:0] alu_res;
  logic             cap_pop;

`ifdef STACK_SEQ_FLAGS_EN
  logic alu_c, alu_z;
`endif

  stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (alu_res)
`ifdef STACK_SEQ_FLAGS_EN
    ,
    .c      (alu_c),
    .z      (alu_z)
`endif
  );

  // Command FSM: registered strobes/done/err are set on the edge entering
  // the cycle in which they must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op      <= '0;
      a       <= '0;
      b       <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      tos_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      tos_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && ready_q) begin
            op      <= cmd_op;
            ready_q <= 1'b0;
            err_q   <= '0;
            if (cmd_op != OP_PUSHI && stk_empty) begin
              state            <= ST_ERR;
              done_q           <= 1'b1;
              err_q[ERR_UNDER] <= 1'b1;
            end else if ((cmd_op == OP_PUSHI || cmd_op == OP_DUP) && stk_full) begin
              state           <= ST_ERR;
              done_q          <= 1'b1;
              err_q[ERR_OVER] <= 1'b1;
            end else begin
              case (cmd_op)
                OP_PUSHI: begin
                  a      <= cmd_imm;
                  state  <= ST_PUSH_R;
                  push_q <= 1'b1;
                  done_q <= 1'b1;
                end
                OP_PEEK, OP_DUP: begin
                  state <= ST_TOS_A;
                  tos_q <= 1'b1;
                end
                default: begin
                  state <= ST_POP_A;
                  pop_q <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_POP_A, ST_TOS_A: begin
          state <= ST_CAP_A;
          if (is_readout(op)) done_q <= 1'b1;
        end
        ST_CAP_A: begin
          a <= stk_data_out;
          if (is_readout(op)) begin
            res_q   <= stk_data_out;
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end else if (!is_binop(op)) begin
            state  <= ST_PUSH_R;
            push_q <= 1'b1;
            done_q <= 1'b1;
          end else if (stk_empty) begin
            // Only one entry was present: put it back and flag underflow.
            state            <= ST_RESTORE;
            push_q           <= 1'b1;
            done_q           <= 1'b1;
            err_q[ERR_UNDER] <= 1'b1;
          end else begin
            state <= ST_CAP_B;
          end
        end
        ST_CAP_B: begin
          b      <= stk_data_out;
          state  <= ST_PUSH_R;
          push_q <= 1'b1;
          done_q <= 1'b1;
        end
        ST_PUSH_R: begin
          res_q   <= alu_res;
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        ST_RESTORE: begin
          res_q   <= a;
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef STACK_SEQ_FLAGS_EN
  // Flags follow arithmetic pushes only; AND and data moves leave them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (state == ST_PUSH_R &&
                 (op == OP_ADD || op == OP_SUB || op == OP_NOT)) begin
      flag_c <= alu_c;
      flag_z <= alu_z;
    end
  end
`endif

  // Second pop of a binary op depends on stk_empty after the first pop,
  // which is only known during CAP_A itself.
  assign cap_pop = (state == ST_CAP_A) && is_binop(op) && !stk_empty;

  // Result visible in the done cycle: captured data for DROP/PEEK arrives
  // straight from the Stack's register, pushed values come from the datapath.
  always_comb begin
    res_data = res_q;
    case (state)
      ST_CAP_A:   if (is_readout(op)) res_data = stk_data_out;
      ST_PUSH_R:  res_data = alu_res;
      ST_RESTORE: res_data = a;
      default:    res_data = res_q;
    endcase
  end

  // Push data is only meaningful while stk_push is high.
  always_comb begin
    stk_data_in = '0;
    if (state == ST_PUSH_R)       stk_data_in = alu_res;
    else if (state == ST_RESTORE) stk_data_in = a;
  end

  // rst kills strobes and done in the cycle it is asserted.
  assign stk_push  = push_q & ~rst;
  assign stk_pop   = (pop_q | cap_pop) & ~rst;
  assign stk_tos   = tos_q & ~rst;
  assign done      = done_q & ~rst;
  assign err       = err_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: behavioural Stack (WIDTH 5, DEPTH 32) plus a
// command-level queue model; directed scenarios followed by random commands.
module tb_stack_op_sequencer;
  import stack_seq_pkg::*;

  localparam int W     = 5;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_imm = '0;
  logic         cmd_ready, stk_push, stk_pop, stk_tos, stk_full, stk_empty, done;
  logic [W-1:0] stk_data_in, stk_data_out, res_data;
  logic [1:0]   err;
`ifdef STACK_SEQ_FLAGS_EN
  logic         flag_c, flag_z;
`endif

  always #5 clk = ~clk;

  stack_op_sequencer #(.WIDTH(W), .OPW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_imm      (cmd_imm),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_tos      (stk_tos),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .done         (done),
    .res_data     (res_data),
    .err          (err)
`ifdef STACK_SEQ_FLAGS_EN
    ,
    .flag_c       (flag_c),
    .flag_z       (flag_z)
`endif
  );

  // Behavioural Stack: registered data_out, shares rst with the sequencer.
  logic [W-1:0] mem [DEPTH];
  logic [5:0]   cnt = '0;
  logic [W-1:0] sdout = '0;
  logic [4:0]   top_idx;
  assign top_idx      = 5'(cnt - 6'd1);
  assign stk_empty    = (cnt == 6'd0);
  assign stk_full     = (cnt == 6'(DEPTH));
  assign stk_data_out = sdout;

  always @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sdout <= '0;
    end else if (stk_push && !stk_full) begin
      mem[cnt[4:0]] <= stk_data_in;
      cnt           <= cnt + 6'd1;
    end else if (stk_pop && !stk_empty) begin
      sdout <= mem[top_idx];
      cnt   <= cnt - 6'd1;
    end else if (stk_tos && !stk_empty) begin
      sdout <= mem[top_idx];
    end
  end

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] last_res = '0;
  logic         fc = 1'b0, fz = 1'b0;
  int           vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_res", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    rst = 1'b0;
    q.delete();
    last_res = '0;
    fc = 1'b0;
    fz = 1'b0;
  endtask

  // Issue one command at a negedge, then follow it to done and one cycle past.
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] imm);
    int           ecyc, epush, epop, etos, npush, npop, ntos, cyc_done, n;
    logic [1:0]   eerr, gerr;
    logic [W-1:0] eres, gres, va, vb, r;
    bit           seen;
    eres = last_res; eerr = 2'b00; ecyc = 1;
    epush = 0; epop = 0; etos = 0;
    npush = 0; npop = 0; ntos = 0; cyc_done = 0;
    seen = 1'b0; gres = '0; gerr = '0;
    if (op == OP_PUSHI) begin
      if (q.size() == DEPTH) eerr = 2'b10;
      else begin q.push_back(imm); eres = imm; epush = 1; end
    end else if (q.size() == 0) begin
      eerr = 2'b01;
    end else if (op == OP_DUP && q.size() == DEPTH) begin
      eerr = 2'b10;
    end else begin
      case (op)
        OP_DROP: begin eres = q.pop_back(); ecyc = 2; epop = 1; end
        OP_PEEK: begin eres = q[$]; ecyc = 2; etos = 1; end
        OP_DUP:  begin eres = q[$]; q.push_back(eres); ecyc = 3; etos = 1; epush = 1; end
        OP_NOT: begin
          va = q.pop_back(); r = ~va; q.push_back(r);
          eres = r; ecyc = 3; epop = 1; epush = 1;
          fc = 1'b0; fz = (r == 0);
        end
        default: begin
          if (q.size() == 1) begin
            eres = q[$]; eerr = 2'b01; ecyc = 3; epop = 1; epush = 1;
          end else begin
            va = q.pop_back(); vb = q.pop_back();
            if (op == OP_ADD)      r = vb + va;
            else if (op == OP_SUB) r = vb - va;
            else                   r = vb & va;
            q.push_back(r);
            eres = r; ecyc = 4; epop = 2; epush = 1;
            if (op == OP_ADD) begin fc = (int'(vb) + int'(va)) > 31; fz = (r == 0); end
            if (op == OP_SUB) begin fc = (vb < va); fz = (r == 0); end
          end
        end
      endcase
    end

    chk("ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      n = int'(stk_push) + int'(stk_pop) + int'(stk_tos);
      chk("one_strobe", n <= 1, 1);
      npush += int'(stk_push); npop += int'(stk_pop); ntos += int'(stk_tos);
      if (done) begin seen = 1'b1; cyc_done = c; gres = res_data; gerr = err; end
    end
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      chk("done_cycle", cyc_done, ecyc);
      chk("res_data", gres, eres);
      chk("err", gerr, eerr);
    end
    chk("n_push", npush, epush);
    chk("n_pop", npop, epop);
    chk("n_tos", ntos, etos);
    @(negedge clk);
    chk("ready_after", cmd_ready, 1);
    chk("done_pulse", done, 0);
    chk("depth", cnt, q.size());
    if (cnt != 0 && q.size() != 0) chk("top", mem[top_idx], q[$]);
`ifdef STACK_SEQ_FLAGS_EN
    chk("flag_c", flag_c, fc);
    chk("flag_z", flag_z, fz);
`endif
    last_res = eres;
  endtask

  initial begin
    logic [2:0] rop;
    int         r;

    do_reset();
    // Basic arithmetic and readback
    do_cmd(OP_PUSHI, 5'd3);
    do_cmd(OP_PUSHI, 5'd7);
    do_cmd(OP_ADD, 5'd0);
    do_cmd(OP_PEEK, 5'd0);
    do_cmd(OP_PUSHI, 5'd2);
    do_cmd(OP_PUSHI, 5'd5);
    do_cmd(OP_SUB, 5'd0);
    do_cmd(OP_AND, 5'd0);
    do_cmd(OP_NOT, 5'd0);
    do_cmd(OP_DUP, 5'd0);

    // Empty-stack underflow
    do_reset();
    do_cmd(OP_DROP, 5'd0);

    // Single-entry binary op: restore path
    do_reset();
    do_cmd(OP_PUSHI, 5'd9);
    do_cmd(OP_ADD, 5'd0);
    do_cmd(OP_PEEK, 5'd0);

    // Fill to full, then overflow on PUSHI and DUP
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSHI, 5'(i));
    do_cmd(OP_PUSHI, 5'd1);
    do_cmd(OP_DUP, 5'd0);
    do_cmd(OP_DROP, 5'd0);

    // Random commands, biased toward pushes, with occasional resets
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 10));
      rop = (r >= 8) ? OP_PUSHI : 3'(r);
      do_cmd(rop, 5'($urandom));
      if ($urandom_range(0, 79) == 0) do_reset();
    end

    // Reset during CAP_B of an ADD
    do_reset();
    do_cmd(OP_PUSHI, 5'd4);
    do_cmd(OP_PUSHI, 5'd6);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_imm = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("capb_no_done", done, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    chk("midrst_empty", stk_empty, 1);
    q.delete();
    last_res = '0;
    fc = 1'b0;
    fz = 1'b0;
    do_cmd(OP_PUSHI, 5'd17);
    do_cmd(OP_PEEK, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
Command-driven controller that sits directly upstream of the team's Stack block (WIDTH 5, DEPTH 32) and is its only master. It accepts one stack-machine command at a time over a valid/ready handshake and drives the Stack's push/pop/tos/data_in strobes. It captures the Stack's registered data_out, performs a small ALU operation and pushes the result back. It reports completion, result value and error status to the processor control path.

Parameters:
WIDTH, 5, data word width; must equal the Stack's WIDTH.
OPW, 3, opcode width.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset; the same net also resets the Stack
cmd_valid  input  1  command offered
cmd_ready  output  1  high only in IDLE
cmd_op  input  OPW  opcode: 000 PUSHI, 001 DROP, 010 PEEK, 011 DUP, 100 ADD, 101 SUB, 110 AND, 111 NOT
cmd_imm  input  WIDTH  immediate for PUSHI
stk_push  output  1  to Stack push
stk_pop  output  1  to Stack pop
stk_tos  output  1  to Stack tos
stk_data_in  output  WIDTH  to Stack data_in
stk_data_out  input  WIDTH  from Stack; registered, valid the cycle after pop/tos
stk_full  input  1  from Stack
stk_empty  input  1  from Stack
done  output  1  one-cycle completion pulse
res_data  output  WIDTH  value pushed, peeked or dropped; held until next done
err  output  2  [0] underflow, [1] overflow; valid with done

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, cmd_ready 1, done 0, res_data 0, err 00, all stk_* strobes 0, operand registers a and b 0.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready. The block latches op and imm, and the accept cycle is cycle 0. cmd_ready stays 0 until the cycle after done.
- Strobes: at most one of stk_push/stk_pop/stk_tos is high in any cycle. Each strobe lasts one cycle.
- Checks at accept, using stk_empty/stk_full sampled in cycle 0:
  - DROP/PEEK/DUP/ADD/SUB/AND/NOT on empty -> ERR state: done in cycle 1, err=01, no strobe issued.
  - PUSHI/DUP on full -> ERR state: done in cycle 1, err=10.
- States: IDLE, POP_A, TOS_A, CAP_A, CAP_B, PUSH_R, RESTORE, ERR.
- Sequences (done cycle in brackets):
  - PUSHI: PUSH_R drives stk_data_in=imm [1].
  - DROP: POP_A, CAP_A latches a; res_data=a [2].
  - PEEK: TOS_A, CAP_A; res_data=a [2].
  - DUP: TOS_A, CAP_A, PUSH_R pushes a [3].
  - NOT: POP_A, CAP_A, PUSH_R pushes ~a [3].
  - ADD/SUB/AND:
    - POP_A.
    - CAP_A latches a (top of stack). If stk_empty, go to RESTORE; otherwise assert stk_pop in CAP_A.
    - CAP_B latches b.
    - PUSH_R pushes the result [4].
- Arithmetic: ADD = b+a, SUB = b-a, AND = b&a, each truncated mod 2^WIDTH; wrap-around is not an error.
- Binary-op underflow: with exactly one entry, RESTORE pushes a back (cycle 3). done fires in that cycle with err=01 and res_data=a. Net stack contents are unchanged.
- done and error: on done, res_data = the value pushed, or the value captured for DROP/PEEK. err=00 on success. The next state is IDLE.
- Reset mid-operation: rst in any state forces IDLE on the next edge, drops all strobes that cycle and suppresses done. The Stack clears on the same rst.
- Illegal opcode: none; all 8 encodings are defined.

Optional Feature:
- Macro STACK_SEQ_FLAGS_EN defined:
  - Adds outputs flag_c (1) and flag_z (1), registered on every PUSH_R of ADD/SUB/NOT and reset to 0.
  - flag_c = carry-out for ADD, borrow (b<a) for SUB, 0 for NOT.
  - flag_z = (result==0).
  - AND, PUSHI, DUP, DROP and PEEK leave the flags unchanged.
- Macro undefined: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Package stack_seq_pkg: opcode constants (OP_PUSHI..OP_NOT), state encoding constants, and err bit indices ERR_UNDER=0, ERR_OVER=1.
- One sub-module stack_seq_alu: combinational; inputs op, a, b; outputs result and, under STACK_SEQ_FLAGS_EN, c and z. It is instantiated once in PUSH_R's datapath.
- The FSM and the Stack strobe logic stay in the top module.

Test Plan:
- rst; PUSHI 3, PUSHI 7, ADD -> ADD done in cycle 4, res_data=10, err=00; following PEEK -> done cycle 2, res_data=10.
- PUSHI 2, PUSHI 5, SUB -> res_data=29 (wrap); with STACK_SEQ_FLAGS_EN, flag_c=1 and flag_z=0.
- Empty stack, DROP -> done cycle 1, err=01, stk_pop never asserted; cmd_ready returns high in cycle 2.
- Single entry 9, ADD -> underflow detected in CAP_A, RESTORE pushes 9, err=01, res_data=9; subsequent PEEK returns 9 and stk_empty=0.
- 32 PUSHIs (values 0..31), then PUSHI 1 -> err=10, no stk_push; then DUP -> err=10; then DROP -> res_data=31.
- rst asserted during CAP_B of an ADD -> next cycle IDLE, cmd_ready=1, done=0, all stk_* strobes 0, stk_empty=1.
